// File: rtl/rf_mover_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_mover_pkg
//  Description : Shared types for the RF move responder: FSM state encoding
//                and the command record as issued by the control unit.
//  Revision    : 1.0  initial release
// ============================================================================
package rf_mover_pkg;

   // Line-address width of the command record as seen by the control unit
   localparam int CMD_ADDR_W = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } mover_state_t;

   typedef struct packed {
      logic [CMD_ADDR_W-1:0] src;
      logic [CMD_ADDR_W-1:0] dst;
      logic [CMD_ADDR_W:0]   line_num;
      logic                  src_freeze;
      logic                  dst_freeze;
   } move_cmd_t;

endpackage : rf_mover_pkg
`default_nettype wire

// File: rtl/rf_mover_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_mover_if
//  Description : Command handshake plus RF "move" RAM port seen by rf_mover.
//                slave = mover side, master = controller / RAM side.
//  Revision    : 1.0  initial release
// ============================================================================
interface rf_mover_if #(
   parameter int RF_ADDR_W = 10,
   parameter int DATA_W    = 256
);
   // command from the control unit
   logic                 start;
   logic [RF_ADDR_W-1:0] src_addr;
   logic [RF_ADDR_W-1:0] dst_addr;
   logic [RF_ADDR_W:0]   line_num;
   logic                 src_freeze;
   logic                 dst_freeze;
   logic                 grant;
   // status back to the control unit
   logic                 busy;
   logic                 done;
   logic                 err;
   // RF move port
   logic                 rd_en;
   logic [RF_ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0]    rd_data;
   logic                 wr_en;
   logic [RF_ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0]    wr_data;

   modport slave (
      input  start, src_addr, dst_addr, line_num, src_freeze, dst_freeze, grant, rd_data,
      output busy, done, err, rd_en, rd_addr, wr_en, wr_addr, wr_data
   );

   modport master (
      output start, src_addr, dst_addr, line_num, src_freeze, dst_freeze, grant, rd_data,
      input  busy, done, err, rd_en, rd_addr, wr_en, wr_addr, wr_data
   );

endinterface : rf_mover_if
`default_nettype wire

// File: rtl/rf_move_delay_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : rf_move_delay_pipe
//  Description : DEPTH-stage valid + payload shift pipe. Carries each read's
//                destination address until its data returns from the RF.
//                Synchronous clear on reset or flush.
//  Revision    : 1.0  initial release
// ============================================================================
module rf_move_delay_pipe #(
   parameter int W     = 10,
   parameter int DEPTH = 1
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   input  wire logic         flush_i,
   input  wire logic         valid_i,
   input  wire logic [W-1:0] data_i,
   output logic              valid_o,
   output logic [W-1:0]      data_o,
   output logic              pending_o
);

   logic [DEPTH-1:0] valid_q;
   logic [W-1:0]     data_q [DEPTH];

   // Shift register; flush discards every in-flight entry
   always_ff @(posedge clk) begin
      if (!rst_n || flush_i) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      end else begin
         valid_q[0] <= valid_i;
         data_q[0]  <= data_i;
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            data_q[i]  <= data_q[i-1];
         end
      end
   end

   assign valid_o = valid_q[DEPTH-1];
   assign data_o  = data_q[DEPTH-1];

   // Entries still behind the output stage: the pipe is not empty after this edge
   generate
      if (DEPTH > 1) begin : g_pend
         assign pending_o = |valid_q[DEPTH-2:0];
      end else begin : g_no_pend
         assign pending_o = 1'b0;
      end
   endgenerate

endmodule : rf_move_delay_pipe
`default_nettype wire

// File: rtl/rf_mover.sv
`default_nettype none
// ============================================================================
//  Module      : rf_mover
//  Description : RF->RF line copy responder. Issues one read per cycle from
//                the source range, writes each returned line to the matching
//                destination line RD_LAT cycles later, pulses done at the end.
//                Loss of grant aborts the move and sets a sticky error.
//  Revision    : 1.0  initial release
// ============================================================================
module rf_mover
   import rf_mover_pkg::*;
#(
   parameter int RF_ADDR_W = 10,
   parameter int DATA_W    = 256,
   parameter int RD_LAT    = 1
) (
   input  wire logic  clk,
   input  wire logic  rst_n,
   rf_mover_if.slave  mv
);

   mover_state_t         state_q, state_d;
   logic [RF_ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [RF_ADDR_W-1:0] dst_addr_q, dst_addr_d;
   logic [RF_ADDR_W:0]   remain_q, remain_d;
   logic                 src_frz_q, src_frz_d;
   logic                 dst_frz_q, dst_frz_d;
   logic                 err_q, err_d;

   logic                 abort;
   logic                 rd_fire;
   logic                 busy;
   logic                 pipe_valid;
   logic                 pipe_pending;
   logic [RF_ADDR_W-1:0] pipe_addr;

   // State and command registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rd_addr_q  <= '0;
         dst_addr_q <= '0;
         remain_q   <= '0;
         src_frz_q  <= 1'b0;
         dst_frz_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_addr_q  <= rd_addr_d;
         dst_addr_q <= dst_addr_d;
         remain_q   <= remain_d;
         src_frz_q  <= src_frz_d;
         dst_frz_q  <= dst_frz_d;
         err_q      <= err_d;
      end
   end

   // Next state: accept command, step addresses per read, drain, finish
   always_comb begin
      state_d    = state_q;
      rd_addr_d  = rd_addr_q;
      dst_addr_d = dst_addr_q;
      remain_d   = remain_q;
      src_frz_d  = src_frz_q;
      dst_frz_d  = dst_frz_q;
      err_d      = err_q;
      abort      = 1'b0;
      case (state_q)
         IDLE: begin
            if (mv.start) begin
               rd_addr_d  = mv.src_addr;
               dst_addr_d = mv.dst_addr;
               remain_d   = mv.line_num;
               src_frz_d  = mv.src_freeze;
               dst_frz_d  = mv.dst_freeze;
               err_d      = 1'b0;
               state_d    = (mv.line_num == '0) ? FIN : READ;
            end
         end
         READ: begin
            if (!mv.grant) begin
               abort   = 1'b1;
               err_d   = 1'b1;
               state_d = FIN;
            end else begin
               // address registers wrap naturally at RF_ADDR_W bits
               rd_addr_d  = rd_addr_q + RF_ADDR_W'(!src_frz_q);
               dst_addr_d = dst_addr_q + RF_ADDR_W'(!dst_frz_q);
               remain_d   = remain_q - (RF_ADDR_W+1)'(1);
               if (remain_q == (RF_ADDR_W+1)'(1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!mv.grant) begin
               abort   = 1'b1;
               err_d   = 1'b1;
               state_d = FIN;
            end else if (!pipe_pending) begin
               state_d = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign rd_fire = (state_q == READ) && mv.grant;
   assign busy    = (state_q == READ) || (state_q == DRAIN);

   rf_move_delay_pipe #(
      .W     (RF_ADDR_W),
      .DEPTH (RD_LAT)
   ) u_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush_i   (abort),
      .valid_i   (rd_fire),
      .data_i    (dst_addr_q),
      .valid_o   (pipe_valid),
      .data_o    (pipe_addr),
      .pending_o (pipe_pending)
   );

   assign mv.busy    = busy;
   assign mv.done    = (state_q == FIN);
   assign mv.err     = err_q;
   assign mv.rd_en   = rd_fire;
   assign mv.rd_addr = rd_addr_q;
   // a write is suppressed in the cycle grant is lost
   assign mv.wr_en   = pipe_valid && mv.grant && busy;
   assign mv.wr_addr = pipe_addr;
   assign mv.wr_data = mv.rd_data;

endmodule : rf_mover
`default_nettype wire

// File: tb/tb_rf_mover.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_mover
//  Description : Self-checking bench for rf_mover with an RF RAM model and a
//                cycle-indexed expectation table built from the move rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rf_mover;

   localparam int AW   = 10;
   localparam int DW   = 256;
   localparam int L    = 1;
   localparam int NL   = 1 << AW;
   localparam int MAXC = 128;
   localparam int NR   = 100000;   // "no reset" marker

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rf_mover_if #(.RF_ADDR_W(AW), .DATA_W(DW)) bus ();

   rf_mover #(.RF_ADDR_W(AW), .DATA_W(DW), .RD_LAT(L)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .mv    (bus.slave)
   );

   // ---------------- RF RAM model ----------------
   logic [DW-1:0] mem [NL];
   logic [DW-1:0] rdq [L];
   logic          ld_en = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [DW-1:0] ld_data = '0;

   always @(posedge clk) begin
      rdq[0] <= mem[bus.rd_addr];
      for (int i = 1; i < L; i++) rdq[i] <= rdq[i-1];
      if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
      if (ld_en)     mem[ld_addr] <= ld_data;
   end
   assign bus.rd_data = rdq[L-1];

   int cycle_count = 0;
   always @(posedge clk) cycle_count <= cycle_count + 1;

   // ---------------- expectation tables ----------------
   bit            e_busy [MAXC];
   bit            e_done [MAXC];
   bit            e_err  [MAXC];
   bit            e_rd   [MAXC];
   bit            e_wr   [MAXC];
   logic [AW-1:0] e_ra   [MAXC];
   logic [AW-1:0] e_wa   [MAXC];
   logic [DW-1:0] e_wd   [MAXC];
   logic [DW-1:0] orig   [NL];
   logic [DW-1:0] expm   [NL];
   bit            err_model = 1'b0;

   bit chk_en = 1'b0;
   int base = 0;
   int pin_last = 0;
   bit pin_en = 1'b0;
   int p_done, p_rd, p_wr, p_fwc, p_fwa, p_lwa;

   int n_pass = 0;
   int n_total = 0;

   // observed per-command statistics (compare process only)
   int rd_cnt, wr_cnt, first_wc, first_wa, last_wa, done_c;

   function automatic logic [DW-1:0] rnd_line();
      logic [DW-1:0] v;
      for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic clear_tables(input bit errv);
      for (int c = 0; c < MAXC; c++) begin
         e_busy[c] = 0; e_done[c] = 0; e_rd[c] = 0; e_wr[c] = 0;
         e_ra[c] = '0; e_wa[c] = '0; e_wd[c] = '0; e_err[c] = errv;
      end
   endtask

   // Expected behaviour of one command, indexed by cycle after the start edge
   task automatic model_cmd(input int src, input int dst, input int n, input bit sf, input bit df,
                            input int glo, input int ghi, input int rstc, output int fin_c);
      int abortc;
      int k_src, k_dst;
      abortc = 0;
      clear_tables(1'b0);
      e_err[0] = err_model;
      if (n == 0) begin
         fin_c = 1;
      end else begin
         for (int c = 1; c <= n + L; c++)
            if (abortc == 0 && c >= glo && c <= ghi) abortc = c;
         fin_c = (abortc != 0) ? abortc + 1 : n + L + 1;
         for (int c = 1; c < fin_c; c++) e_busy[c] = 1;
         for (int k = 0; k < n; k++) begin
            k_src = (src + (sf ? 0 : k)) % NL;
            k_dst = (dst + (df ? 0 : k)) % NL;
            if (abortc == 0 || k + 1 < abortc) begin
               e_rd[k+1] = 1; e_ra[k+1] = AW'(k_src);
            end
            if (abortc == 0 || k + 1 + L < abortc) begin
               e_wr[k+1+L] = 1; e_wa[k+1+L] = AW'(k_dst); e_wd[k+1+L] = orig[k_src];
            end
         end
         if (abortc != 0)
            for (int c = abortc + 1; c < MAXC; c++) e_err[c] = 1;
      end
      e_done[fin_c] = 1;
      if (rstc < MAXC)
         for (int c = rstc + 1; c < MAXC; c++) begin
            e_busy[c] = 0; e_done[c] = 0; e_rd[c] = 0; e_wr[c] = 0; e_err[c] = 0;
         end
      for (int i = 0; i < NL; i++) expm[i] = orig[i];
      for (int c = 0; c < MAXC; c++) if (e_wr[c]) expm[e_wa[c]] = e_wd[c];
   endtask

   task automatic run_cmd(input int src, input int dst, input int n, input bit sf, input bit df,
                          input int glo, input int ghi, input int rstc, input int rsc,
                          input bit pe, input int pd, input int prd, input int pwr,
                          input int pfwc, input int pfwa, input int plwa);
      int fin_c, last;
      for (int i = 0; i < NL; i++) orig[i] = mem[i];
      model_cmd(src, dst, n, sf, df, glo, ghi, rstc, fin_c);
      last = fin_c + 2;
      if (rstc < MAXC && rstc + 2 > last) last = rstc + 2;
      pin_last = last; pin_en = pe;
      p_done = pd; p_rd = prd; p_wr = pwr; p_fwc = pfwc; p_fwa = pfwa; p_lwa = plwa;
      @(posedge clk); #2;
      base = cycle_count;
      chk_en = 1'b1;
      bus.start = 1'b1;
      bus.src_addr = AW'(src); bus.dst_addr = AW'(dst); bus.line_num = (AW+1)'(n);
      bus.src_freeze = sf; bus.dst_freeze = df;
      bus.grant = !(0 >= glo && 0 <= ghi);
      for (int c = 1; c <= last; c++) begin
         @(posedge clk); #2;
         bus.start = (c == rsc);
         if (c == rsc) begin
            bus.src_addr = AW'($urandom); bus.dst_addr = AW'($urandom);
            bus.line_num = (AW+1)'($urandom_range(1, 30));
            bus.src_freeze = 1'($urandom); bus.dst_freeze = 1'($urandom);
         end
         bus.grant = !(c >= glo && c <= ghi);
         rst_n = !(c == rstc);
      end
      @(negedge clk); #1;
      chk_en = 1'b0; bus.start = 1'b0; bus.grant = 1'b1; rst_n = 1'b1;
      err_model = e_err[last];
   endtask

   task automatic run_idle(input int k);
      for (int i = 0; i < NL; i++) begin orig[i] = mem[i]; expm[i] = mem[i]; end
      clear_tables(err_model);
      pin_last = k; pin_en = 1'b0;
      @(posedge clk); #2;
      base = cycle_count;
      chk_en = 1'b1;
      for (int c = 1; c <= k; c++) begin @(posedge clk); #2; end
      @(negedge clk); #1;
      chk_en = 1'b0;
   endtask

   task automatic chk(input string nm, input int c, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
   endtask

   // Compare process: DUT outputs against the expectation tables every cycle
   always @(negedge clk) begin : cmp
      int c, mism;
      if (chk_en) begin
         c = cycle_count - base;
         if (c >= 0 && c < MAXC) begin
            if (c == 0) begin
               rd_cnt = 0; wr_cnt = 0; first_wc = -1; first_wa = -1; last_wa = -1; done_c = -1;
            end
            chk("busy",  c, DW'(bus.busy),  DW'(e_busy[c]));
            chk("done",  c, DW'(bus.done),  DW'(e_done[c]));
            chk("err",   c, DW'(bus.err),   DW'(e_err[c]));
            chk("rd_en", c, DW'(bus.rd_en), DW'(e_rd[c]));
            chk("wr_en", c, DW'(bus.wr_en), DW'(e_wr[c]));
            if (e_rd[c]) chk("rd_addr", c, DW'(bus.rd_addr), DW'(e_ra[c]));
            if (e_wr[c]) begin
               chk("wr_addr", c, DW'(bus.wr_addr), DW'(e_wa[c]));
               chk("wr_data", c, bus.wr_data, e_wd[c]);
            end
            if (bus.rd_en) rd_cnt++;
            if (bus.wr_en) begin
               wr_cnt++;
               if (first_wc < 0) begin first_wc = c; first_wa = int'(bus.wr_addr); end
               last_wa = int'(bus.wr_addr);
            end
            if (bus.done && done_c < 0) done_c = c;
            if (c == pin_last) begin
               mism = 0;
               for (int i = 0; i < NL; i++) if (mem[i] !== expm[i]) mism++;
               chk("mem_lines_wrong", c, DW'(mism), DW'(0));
               if (pin_en) begin
                  chk("done_cycle", c, DW'(done_c), DW'(p_done));
                  chk("rd_count",   c, DW'(rd_cnt), DW'(p_rd));
                  chk("wr_count",   c, DW'(wr_cnt), DW'(p_wr));
                  if (p_fwc >= 0) chk("first_wr_cycle", c, DW'(first_wc), DW'(p_fwc));
                  if (p_fwa >= 0) chk("first_wr_addr",  c, DW'(first_wa), DW'(p_fwa));
                  if (p_lwa >= 0) chk("last_wr_addr",   c, DW'(last_wa),  DW'(p_lwa));
               end
            end
         end
      end
   end

   initial begin
      int n, src, dst, glo, ghi, rsc, hi;
      bit sf, df;
      bus.start = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.line_num = '0;
      bus.src_freeze = 1'b0; bus.dst_freeze = 1'b0; bus.grant = 1'b1;
      // preload RAM with random lines while the DUT is held in reset
      for (int i = 0; i < NL; i++) begin
         @(posedge clk); #2;
         ld_en = 1'b1; ld_addr = AW'(i); ld_data = rnd_line();
      end
      @(posedge clk); #2; ld_en = 1'b0;
      run_idle(3);                     // reset state
      rst_n = 1'b1;
      run_idle(2);

      // src 0x010 -> dst 0x100, 4 lines
      run_cmd('h010, 'h100, 4, 0, 0, -1, -1, NR, -1, 1, 6, 4, 4, 2, 'h100, 'h103);
      // zero lines
      run_cmd('h050, 'h150, 0, 0, 0, -1, -1, NR, -1, 1, 1, 0, 0, -1, -1, -1);
      // address wrap
      run_cmd('h3FE, 'h3FF, 3, 0, 0, -1, -1, NR, -1, 1, 5, 3, 3, 2, 'h3FF, 'h001);
      // source frozen, destination frozen, both frozen
      run_cmd('h020, 'h040, 3, 1, 0, -1, -1, NR, -1, 1, 5, 3, 3, 2, 'h040, 'h042);
      run_cmd('h020, 'h040, 3, 0, 1, -1, -1, NR, -1, 1, 5, 3, 3, 2, 'h040, 'h040);
      run_cmd('h030, 'h060, 3, 1, 1, -1, -1, NR, -1, 1, 5, 3, 3, 2, 'h060, 'h060);
      // grant lost in cycle 3 of an 8-line move, then a clean move clears err
      run_cmd('h200, 'h300, 8, 0, 0, 3, 3, NR, -1, 1, 4, 2, 1, 2, 'h300, 'h300);
      run_cmd('h210, 'h310, 2, 0, 0, -1, -1, NR, -1, 1, 4, 2, 2, 2, 'h310, 'h311);
      // grant low when the command is accepted
      run_cmd('h220, 'h320, 4, 0, 0, 0, 1, NR, -1, 1, 2, 0, 0, -1, -1, -1);
      // restart mid-move and in the done cycle
      run_cmd('h080, 'h180, 5, 0, 0, -1, -1, NR, 2, 1, 7, 5, 5, 2, 'h180, 'h184);
      run_cmd('h0A0, 'h1A0, 2, 0, 0, -1, -1, NR, 4, 1, 4, 2, 2, 2, 'h1A0, 'h1A1);
      // reset during READ
      run_cmd('h0C0, 'h1C0, 8, 0, 0, -1, -1, 3, -1, 1, -1, 3, 2, 2, 'h1C0, 'h1C1);

      // randomized commands
      for (int t = 0; t < 40; t++) begin
         n   = $urandom_range(0, 20);
         src = $urandom_range(0, NL - 1);
         dst = (src + 512 + $urandom_range(0, 255)) % NL;
         sf  = 1'($urandom); df = 1'($urandom);
         glo = -1; ghi = -1; rsc = -1;
         if (n > 0 && $urandom_range(0, 3) == 0) begin
            glo = $urandom_range(0, n + L);
            ghi = glo + $urandom_range(0, 2);
         end
         if ($urandom_range(0, 4) == 0) begin
            hi  = (glo >= 1) ? glo : ((glo == 0) ? 1 : ((n == 0) ? 1 : n + L));
            rsc = $urandom_range(1, hi);
         end
         run_cmd(src, dst, n, sf, df, glo, ghi, NR, rsc, 0, 0, 0, 0, -1, -1, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_rf_mover
`default_nettype wire
